// File: rtl/snake_ctrl.sv
// Game sequencer for snake_field: button edge detect, step pacing that speeds up with length, game FSM.
// All outputs registered; a press appears one cycle later. No backpressure: pulses are fire-and-forget.
module snake_ctrl #(
  parameter int SIZE_X      = 10,
  parameter int SIZE_Y      = 10,
  parameter int SBITS       = $clog2(SIZE_X*SIZE_Y),
  parameter int STEP_PERIOD = 25_000_000,
  parameter int STEP_MIN    = 5_000_000,
  parameter int STEP_DEC    = 1_000_000,
  parameter int TBITS       = $clog2(STEP_PERIOD+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_right,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_start,
  input  logic             snake_alive,
  input  logic [SBITS-1:0] snake_len,
  output logic             start,
  output logic             step,
  output logic [1:0]       snake_dir,
  output logic [SBITS-1:0] seed,
  output logic [1:0]       game_state,
  output logic             game_won
);

  localparam int CELLS = SIZE_X * SIZE_Y;
  localparam logic [TBITS-1:0] PERIOD_T = TBITS'(STEP_PERIOD);
  localparam logic [TBITS-1:0] MIN_T    = TBITS'(STEP_MIN);
  localparam logic [TBITS-1:0] DEC_T    = TBITS'(STEP_DEC);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  state_t           state, state_n;
  logic [TBITS-1:0] timer, timer_n, period, period_n;
  logic [SBITS-1:0] prev_len, prev_len_n, seed_n;
  logic             start_n, step_n, won_n;
  logic [1:0]       dir_n;
  logic [4:0]       btn_now, btn_prev, press;

  assign btn_now    = {btn_start, btn_up, btn_right, btn_down, btn_left};
  assign press      = btn_now & ~btn_prev;
  assign game_state = state;

  always_comb begin
    state_n    = state;
    start_n    = 1'b0;
    step_n     = 1'b0;
    timer_n    = timer;
    period_n   = period;
    prev_len_n = prev_len;
    dir_n      = snake_dir;
    won_n      = game_won;
    seed_n     = (32'(seed) == CELLS - 1) ? '0 : seed + SBITS'(1);

    if (press[4]) begin
      state_n    = PLAY;
      start_n    = 1'b1;
      timer_n    = PERIOD_T;
      period_n   = PERIOD_T;
      prev_len_n = SBITS'(4);
      dir_n      = 2'd1;
      won_n      = 1'b0;
    end else if (state == PLAY) begin
      // Field feedback is stale while start is high; the timer still runs so the first step lands at start+period.
      if (!start) begin
        if      (press[3]) dir_n = 2'd0;
        else if (press[2]) dir_n = 2'd1;
        else if (press[1]) dir_n = 2'd2;
        else if (press[0]) dir_n = 2'd3;
        if (snake_len != prev_len) begin
          prev_len_n = snake_len;
          period_n   = (32'(period) > STEP_MIN + STEP_DEC) ? period - DEC_T : MIN_T;
        end
      end
      if (!start && !snake_alive) begin
        state_n = OVER;
        won_n   = 1'b0;
      end else if (!start && 32'(snake_len) == CELLS) begin
        state_n = OVER;
        won_n   = 1'b1;
      end else if (timer == TBITS'(1)) begin
        step_n  = 1'b1;
        timer_n = period;
      end else if (timer != '0) begin
        timer_n = timer - TBITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      start     <= 1'b0;
      step      <= 1'b0;
      snake_dir <= 2'd1;
      seed      <= '0;
      game_won  <= 1'b0;
      timer     <= '0;
      period    <= PERIOD_T;
      prev_len  <= SBITS'(4);
      btn_prev  <= '0;
    end else begin
      state     <= state_n;
      start     <= start_n;
      step      <= step_n;
      snake_dir <= dir_n;
      seed      <= seed_n;
      game_won  <= won_n;
      timer     <= timer_n;
      period    <= period_n;
      prev_len  <= prev_len_n;
      btn_prev  <= btn_now;
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// Scoreboarded bench for snake_ctrl on a 4x4 field, period 8, floor 4, decrement 2.
// Expected start/step pulses are queued by the stimulus; a monitor pops them as the DUT fires.
module tb_snake_ctrl;

  localparam int EV_START = 0;
  localparam int EV_STEP  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_right, btn_down, btn_left, btn_start;
  logic       snake_alive;
  logic [4:0] snake_len;
  logic       start, step, game_won;
  logic [1:0] snake_dir, game_state;
  logic [4:0] seed;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  snake_ctrl #(
    .SIZE_X(4), .SIZE_Y(4), .SBITS(5),
    .STEP_PERIOD(8), .STEP_MIN(4), .STEP_DEC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
    .btn_start(btn_start), .snake_alive(snake_alive), .snake_len(snake_len),
    .start(start), .step(step), .snake_dir(snake_dir), .seed(seed),
    .game_state(game_state), .game_won(game_won)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s: pulse at cycle %0d, none expected", kind == EV_START ? "start" : "step", cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc) begin
        fails++;
        $display("FAIL pulse: got %s at cycle %0d, expected %s at cycle %0d",
                 kind == EV_START ? "start" : "step", cyc,
                 e.kind == EV_START ? "start" : "step", e.at);
      end
    end
  endtask

  // Monitor: every start/step pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (start) mon_event(EV_START);
    if (step)  mon_event(EV_STEP);
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int c, s3, s4, s5, s6, s7;
    rst_n = 1'b0;
    btn_up = 1'b0; btn_right = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_start = 1'b0;
    snake_alive = 1'b1;
    snake_len = 5'd4;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_start", start, 0);
    check("rst_step", step, 0);
    check("rst_dir", snake_dir, 1);
    check("rst_seed", seed, 0);
    check("rst_state", game_state, 0);
    check("rst_won", game_won, 0);
    rst_n = 1'b1;

    // Free-running seed, wrapping 15 -> 0
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("seed", seed, i % 16);
    end
    check("idle_state", game_state, 0);

    // Start: pulse one cycle after press, steps every 8 from start
    c = cyc;
    btn_start = 1'b1;
    push(EV_START, c + 1);
    push(EV_STEP, c + 9);
    push(EV_STEP, c + 17);
    @(negedge clk);
    btn_start = 1'b0;
    check("play_state", game_state, 1);
    check("play_dir", snake_dir, 1);

    // Speed-up: spacing 8, 6, 4, 4 after successive length changes
    wait_until(c + 17);
    s3 = c + 25; s4 = s3 + 6; s5 = s4 + 4; s6 = s5 + 4; s7 = s6 + 4;
    snake_len = 5'd5;
    push(EV_STEP, s3);
    wait_until(s3);
    snake_len = 5'd6;
    push(EV_STEP, s4);
    wait_until(s4);
    snake_len = 5'd7;
    push(EV_STEP, s5);
    push(EV_STEP, s6);
    push(EV_STEP, s7);
    wait_until(s6);

    // Direction priority, then a single press
    btn_up = 1'b1; btn_left = 1'b1;
    @(negedge clk);
    check("dir_up_over_left", snake_dir, 0);
    btn_up = 1'b0; btn_left = 1'b0; btn_down = 1'b1;
    @(negedge clk);
    check("dir_down", snake_dir, 2);
    btn_down = 1'b0;

    // Death in the same cycle the timer reaches 1
    wait_until(s7 + 3);
    snake_alive = 1'b0;
    @(negedge clk);
    check("death_state", game_state, 2);
    check("death_won", game_won, 0);
    check("death_no_step", step, 0);
    btn_right = 1'b1;
    @(negedge clk);
    btn_right = 1'b0;
    repeat (8) @(negedge clk);
    check("over_dir_ignored", snake_dir, 2);
    check("over_state", game_state, 2);

    // Restart from OVER: period back to 8
    c = cyc;
    btn_start = 1'b1; snake_alive = 1'b1; snake_len = 5'd4;
    push(EV_START, c + 1);
    push(EV_STEP, c + 9);
    push(EV_STEP, c + 17);
    @(negedge clk);
    btn_start = 1'b0;
    check("restart_state", game_state, 1);
    check("restart_dir", snake_dir, 1);
    wait_until(c + 17);

    // Win: field filled while alive
    @(negedge clk);
    snake_len = 5'd16;
    @(negedge clk);
    check("win_state", game_state, 2);
    check("win_won", game_won, 1);
    repeat (10) @(negedge clk);

    // Held start button gives a single pulse
    c = cyc;
    btn_start = 1'b1; snake_len = 5'd4;
    push(EV_START, c + 1);
    push(EV_STEP, c + 9);
    push(EV_STEP, c + 17);
    @(negedge clk);
    check("hold_won_cleared", game_won, 0);
    check("hold_state", game_state, 1);
    repeat (9) @(negedge clk);
    btn_start = 1'b0;

    // Async reset during a step pulse clears outputs before the next edge
    wait_until(c + 17);
    #1 rst_n = 1'b0;
    #1;
    check("arst_step", step, 0);
    check("arst_start", start, 0);
    check("arst_state", game_state, 0);
    check("arst_seed", seed, 0);
    check("arst_dir", snake_dir, 1);
    check("arst_won", game_won, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_state", game_state, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
